// File: rtl/mux4_sel_arbiter_if.sv
// rtl/mux4_sel_arbiter_if.sv - request/select handshake bundle between sources, arbiter and mux consumer
//
// Signals:
//   req[3:0]   per-channel request, bit i selects mux data input di
//   ready      consumer accepts the current selection
//   s0, s1     mux select, channel index = {s1,s0}
//   grant[3:0] one-hot grant, mirrors {s1,s0} while valid=1
//   valid      selection on s1:s0 is current and awaiting ready
//   busy       arbiter is in GRANT or HOLD
//   lock       (MUXSEL_LOCK_EN only) keep the priority pointer on completion
//
// Modports:
//   master  arbiter side (drives select/grant/valid/busy)
//   slave   sources + consumer side (drives req/ready/lock)

interface mux4_sel_arbiter_if;
    logic [3:0] req;
    logic       ready;
    logic       s0;
    logic       s1;
    logic [3:0] grant;
    logic       valid;
    logic       busy;
`ifdef MUXSEL_LOCK_EN
    logic       lock;
`endif

    modport master (
`ifdef MUXSEL_LOCK_EN
        input  lock,
`endif
        input  req,
        input  ready,
        output s0,
        output s1,
        output grant,
        output valid,
        output busy
    );

    modport slave (
`ifdef MUXSEL_LOCK_EN
        output lock,
`endif
        output req,
        output ready,
        input  s0,
        input  s1,
        input  grant,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/mux4_sel_arbiter.sv
// rtl/mux4_sel_arbiter.sv - round-robin 4-channel arbiter driving the select pins of a 4-to-1 mux
//
// Picks one of four requesters, presents its index on s1:s0 with a valid/ready
// handshake, then freezes the select for HOLD_CYCLES cycles after acceptance
// before arbitrating again. The select never moves while a transfer is pending
// or settling, and it keeps its last value while idle.
//
// Parameters:
//   HOLD_CYCLES  post-accept settle cycles (0..255); 0 skips the HOLD state
//
// Optional feature:
//   MUXSEL_LOCK_EN  when defined, bus.lock=1 on the completing ready edge keeps
//                   the priority pointer where it is, so the same channel can
//                   win again; lock is ignored on withdrawal
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux4_sel_arbiter_if.master (req, ready, [lock] in; s0, s1, grant, valid, busy out)

module mux4_sel_arbiter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux4_sel_arbiter_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam bit         HAS_HOLD  = (HOLD_CYCLES > 0);

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;

    logic       keep_ptr;
    logic       win_found;
    logic [1:0] win_idx;

`ifdef MUXSEL_LOCK_EN
    assign keep_ptr = bus.lock;
`else
    assign keep_ptr = 1'b0;
`endif

    // Rotating priority search: first asserted request at or after ptr, mod 4.
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = ptr_q;
        idx       = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Next-state and next-output logic. Every output is produced from a
    // register, so the mux select pins see no combinational glitches.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                grant_d = 4'b0000;
                if (win_found) begin
                    sel_d   = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                // ready takes precedence over a same-edge request drop.
                if (bus.ready) begin
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    cnt_d   = HOLD_LOAD;
                    if (!keep_ptr) begin
                        ptr_d = sel_q + 2'd1;
                    end
                    if (HAS_HOLD) begin
                        state_d = HOLD;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (!bus.req[sel_q]) begin
                    // Withdrawal: drop the grant without rotating priority.
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            HOLD: begin
                cnt_d = cnt_q - 8'd1;
                // <= 1 rather than == 1 so a zero count can never stall here.
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s0    = sel_q[0];
    assign bus.s1    = sel_q[1];
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule
